mul_arb: RTL

//  Round-robin scheduler sharing one iterative booth multiplier (mul) among NUM_REQ requesters.

---
 rtl/mul_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mul_arb.sv
// Round-robin front end for a shared iterative multiplier: grants one RISC-V M op at a time,
// waits out the fixed multiplier latency, then returns the selected product half with its tag.
module mul_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*2-1:0]     req_op,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [31:0]              resp_data,
  output logic [TAG_W-1:0]         resp_tag,
  output logic                     busy,
  output logic                     mul_req_valid,
  output logic                     mul_in_1_signed,
  output logic                     mul_in_2_signed,
  output logic [31:0]              mul_in_1,
  output logic [31:0]              mul_in_2,
  input  logic [63:0]              mul_resp_result
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] owner;
  logic [TAG_W-1:0] tag_q;
  logic             hi_sel;

  logic [31:0]      a_arr   [NUM_REQ];
  logic [31:0]      b_arr   [NUM_REQ];
  logic [1:0]       op_arr  [NUM_REQ];
  logic [TAG_W-1:0] tag_arr [NUM_REQ];

  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] idx;
  logic             hs;
  logic             grant;

  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      a_arr[k]   = req_a[32*k +: 32];
      b_arr[k]   = req_b[32*k +: 32];
      op_arr[k]  = req_op[2*k +: 2];
      tag_arr[k] = req_tag[TAG_W*k +: TAG_W];
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hs    = (state == RESP) && resp_ready[owner];
  assign grant = reset && !flush && found && ((state == IDLE) || hs);
  assign busy  = (state != IDLE);

  always_comb begin
    req_ready       = '0;
    mul_req_valid   = 1'b0;
    mul_in_1_signed = 1'b0;
    mul_in_2_signed = 1'b0;
    mul_in_1        = '0;
    mul_in_2        = '0;
    if (grant) begin
      req_ready       = NUM_REQ'(1) << win;
      mul_req_valid   = 1'b1;
      mul_in_1_signed = (op_arr[win] != 2'b11);
      mul_in_2_signed = !op_arr[win][1];
      mul_in_1        = a_arr[win];
      mul_in_2        = b_arr[win];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rr         <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      tag_q      <= '0;
      hi_sel     <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= '0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_data  <= hi_sel ? mul_resp_result[63:32] : mul_resp_result[31:0];
            resp_tag   <= tag_q;
            resp_valid <= NUM_REQ'(1) << owner;
            state      <= RESP;
          end
        end
        RESP: begin
          if (hs) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A grant overrides the IDLE return of a same-cycle handshake.
      if (grant) begin
        hi_sel <= |op_arr[win];
        tag_q  <= tag_arr[win];
        owner  <= win;
        rr     <= win;
        cnt    <= CNT_W'(MUL_LAT);
        state  <= BUSY;
      end
    end
  end

endmodule
